pipelined_cla_adder: RTL and testbench



---
 rtl/pipelined_cla_adder_pkg.sv | 18 +
 rtl/pipelined_cla_adder_cla.sv | 51 +++++
 rtl/pipelined_cla_adder.sv | 115 +++++++++++
 tb/tb_pipelined_cla_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared types and geometry helpers for the pipelined carry-lookahead adder.
// The width/block split is checked at elaboration.
package pipelined_cla_adder_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  function automatic int unsigned calc_ngrp(input int unsigned width, input int unsigned block);
    return width / block;
  endfunction

  function automatic bit geometry_ok(input int unsigned width, input int unsigned block);
    return (block != 0) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla.sv
// Combinational BLOCK-bit carry-lookahead group: every internal carry is a
// flat sum of generate/propagate products, with no ripple chain.
module cla_block
  import pipelined_cla_adder_pkg::*;
#(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output grp_pg_t          pg,
  output logic             cmsb
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;
  logic             t;
  logic             gg;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    t  = 1'b0;
    gg = 1'b0;
    // c[i] = cin&p[0..i-1] | OR_j ( g[j] & p[j+1..i-1] )
    for (int unsigned i = 0; i <= BLOCK; i++) begin
      c[i] = cin;
      for (int unsigned j = 0; j < i; j++) c[i] = c[i] & p[j];
      for (int unsigned j = 0; j < i; j++) begin
        t = g[j];
        for (int unsigned m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    for (int unsigned j = 0; j < BLOCK; j++) begin
      t = g[j];
      for (int unsigned m = j + 1; m < BLOCK; m++) t = t & p[m];
      gg = gg | t;
    end
  end

  assign sum  = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign cmsb = c[BLOCK-1];
  assign pg.p = &p;
  assign pg.g = gg;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder: one BLOCK-bit group resolved per stage, carry handed
// stage to stage through registers, global-stall valid/ready handshake.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NGRP = calc_ngrp(WIDTH, BLOCK);

  if (!geometry_ok(WIDTH, BLOCK)) begin : g_bad_geometry
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic [WIDTH-1:0] a_q   [NGRP];
  logic [WIDTH-1:0] b_q   [NGRP];
  logic [WIDTH-1:0] s_q   [NGRP];
  logic             c_q   [NGRP];
  logic             v_q   [NGRP];
  logic             cmsb_q;

  logic [WIDTH-1:0] a_nxt [NGRP];
  logic [WIDTH-1:0] b_nxt [NGRP];
  logic [WIDTH-1:0] s_nxt [NGRP];
  logic             v_nxt [NGRP];

  logic [BLOCK-1:0] ga    [NGRP];
  logic [BLOCK-1:0] gb    [NGRP];
  logic [BLOCK-1:0] gs    [NGRP];
  logic             gcin  [NGRP];
  logic             gcout [NGRP];
  logic             gcmsb [NGRP];
  grp_pg_t          gpg   [NGRP];

  logic             advance;

  assign advance  = !v_q[NGRP-1] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign ga[k]    = a[BLOCK-1:0];
      assign gb[k]    = b[BLOCK-1:0];
      assign gcin[k]  = Cin;
      assign v_nxt[k] = in_valid;
      assign a_nxt[k] = (a >> BLOCK) << BLOCK;
      assign b_nxt[k] = (b >> BLOCK) << BLOCK;
      assign s_nxt[k] = WIDTH'(gs[k]);
    end else begin : g_tail
      assign ga[k]    = a_q[k-1][k*BLOCK +: BLOCK];
      assign gb[k]    = b_q[k-1][k*BLOCK +: BLOCK];
      assign gcin[k]  = c_q[k-1];
      assign v_nxt[k] = v_q[k-1];
      // operand bits already consumed are cleared so only pending groups travel on
      assign a_nxt[k] = (a_q[k-1] >> ((k + 1) * BLOCK)) << ((k + 1) * BLOCK);
      assign b_nxt[k] = (b_q[k-1] >> ((k + 1) * BLOCK)) << ((k + 1) * BLOCK);
      assign s_nxt[k] = s_q[k-1] | (WIDTH'(gs[k]) << (k * BLOCK));
    end

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a    (ga[k]),
      .b    (gb[k]),
      .cin  (gcin[k]),
      .sum  (gs[k]),
      .cout (gcout[k]),
      .pg   (gpg[k]),
      .cmsb (gcmsb[k])
    );

    // group P/G must agree with the block's own carry-out
    always_comb assert (gcout[k] == (gpg[k].g | (gpg[k].p & gcin[k])));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NGRP; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      cmsb_q <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < NGRP; k++) begin
        a_q[k] <= a_nxt[k];
        b_q[k] <= b_nxt[k];
        s_q[k] <= s_nxt[k];
        c_q[k] <= gcout[k];
        v_q[k] <= v_nxt[k];
      end
      cmsb_q <= gcmsb[NGRP-1];
    end
  end

  assign out_valid = v_q[NGRP-1];
  assign sum       = s_q[NGRP-1];
  assign cout      = c_q[NGRP-1];
  assign overflow  = cmsb_q ^ c_q[NGRP-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and randomized bench for pipelined_cla_adder (WIDTH=16, BLOCK=4),
// checked against a cycle-level arithmetic reference of the handshake.
module tb_pipelined_cla_adder;

  localparam int LAT = 4;

  typedef struct packed {
    logic        v;
    logic [15:0] s;
    logic        c;
    logic        o;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        Cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int acc_n  = 0;
  int ret_n  = 0;
  int run    = 0;
  int max_run = 0;
  int ret_mark;

  beat_t pipe [LAT];

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic beat_t ref_add(input logic [15:0] x, input logic [15:0] y, input logic ci);
    beat_t r;
    logic [16:0] full;
    full = {1'b0, x} + {1'b0, y} + 17'(ci);
    r.v  = 1'b1;
    r.s  = full[15:0];
    r.c  = full[16];
    r.o  = (x[15] == y[15]) && (full[15] != x[15]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the falling edge, check, then update the reference.
  task automatic cyc(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                     input logic ci, input logic ordy, input logic r);
    beat_t nb;
    @(negedge clk);
    rst = r; in_valid = v; a = aa; b = bb; Cin = ci; out_ready = ordy;
    #1;
    if (r) begin
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
      run = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!pipe[LAT-1].v || ordy));
      chk("out_valid", 32'(out_valid), 32'(pipe[LAT-1].v));
      if (pipe[LAT-1].v) begin
        chk("sum", 32'(sum), 32'(pipe[LAT-1].s));
        chk("cout", 32'(cout), 32'(pipe[LAT-1].c));
        chk("overflow", 32'(overflow), 32'(pipe[LAT-1].o));
      end
      if (out_valid === 1'b1 && ordy) begin
        ret_n++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (!pipe[LAT-1].v || ordy) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        nb = ref_add(aa, bb, ci);
        nb.v = v;
        pipe[0] = nb;
        if (v) acc_n++;
      end
    end
  endtask

  task automatic expect_result(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    do begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      n++;
    end while (out_valid !== 1'b1 && n < 12);
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic [15:0] es, input logic ec, input logic eo);
    cyc(1'b1, x, y, ci, 1'b1, 1'b0);
    expect_result(tag, es, ec, eo);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * LAT; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) pipe[i] = '0;

    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    directed("add_3_7", 16'h0003, 16'h0007, 1'b0, 16'h000A, 1'b0, 1'b0);
    directed("add_f_f", 16'h000F, 16'h000F, 1'b0, 16'h001E, 1'b0, 1'b0);
    directed("ripple_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ripple_ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    directed("ovf_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    drain();

    ret_mark = ret_n;
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      logic ci;
      ci = i[0];
      cyc(1'b1, 16'(i * 32'h1111), 16'h0101, ci, 1'b1, 1'b0);
    end
    drain();
    chk("thru_count", 32'(ret_n - ret_mark), 32'd8);
    chk("thru_run", 32'(max_run), 32'd8);

    for (int i = 0; i < LAT; i++)
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
    end
    cyc(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0);
    drain();
    chk("bp_no_loss", 32'(ret_n), 32'(acc_n));

    for (int i = 0; i < 3; i++)
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    acc_n = 0;
    ret_n = 0;
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("midrst_no_stale", 32'(ret_n), 32'd0);
    directed("post_rst", 16'h1234, 16'h0FF1, 1'b1, 16'h2226, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) != 0), 1'b0);
    drain();
    chk("rand_no_loss", 32'(ret_n), 32'(acc_n));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
